// File: rtl/sirv_debug_pkg.sv
// Shared definitions for the commit-stage debug entry/exit controller:
// dcause encodings, controller states and the default debug ROM address.
package sirv_debug_pkg;

   localparam logic [2:0] DCAUSE_NONE   = 3'd0;
   localparam logic [2:0] DCAUSE_EBREAK = 3'd1;
   localparam logic [2:0] DCAUSE_IRQ    = 3'd3;
   localparam logic [2:0] DCAUSE_STEP   = 3'd4;
   localparam logic [2:0] DCAUSE_HALT   = 3'd5;

   localparam logic [31:0] DEF_DEBUG_ROM_ADDR = 32'h0000_0800;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STEP,
      ST_ENT_FLUSH,
      ST_DEBUG,
      ST_EXIT_FLUSH
   } dbg_state_e;

endpackage

// File: rtl/sirv_debug_entry_ctrl.sv
// Decides debug-mode entry at commit, drives dpc/dcause capture strobes into
// the debug CSR block and requests flushes to the debug ROM or back to dpc.
module sirv_debug_entry_ctrl
   import sirv_debug_pkg::*;
#(
   parameter int          PC_SIZE        = 32,
   parameter logic [31:0] DEBUG_ROM_ADDR = DEF_DEBUG_ROM_ADDR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmt_valid,
   input  logic [PC_SIZE-1:0] cmt_pc,
   input  logic [PC_SIZE-1:0] cmt_next_pc,
   input  logic               cmt_ebreak,
   input  logic               cmt_dret,
   input  logic [PC_SIZE-1:0] nxt_pc,
   input  logic               dbg_irq_r,
   input  logic               dbg_halt_r,
   input  logic               dbg_step_r,
   input  logic               dbg_ebreakm_r,
   input  logic [PC_SIZE-1:0] dpc_r,
   output logic [PC_SIZE-1:0] cmt_dpc,
   output logic               cmt_dpc_ena,
   output logic [2:0]         cmt_dcause,
   output logic               cmt_dcause_ena,
   output logic               flush_req,
   output logic [PC_SIZE-1:0] flush_pc,
   input  logic               flush_ack,
   output logic               cmt_hold,
   output logic               dbg_active
);

   localparam logic [PC_SIZE-1:0] ROM_PC = PC_SIZE'(DEBUG_ROM_ADDR);

   dbg_state_e         state, state_nxt;
   logic               flush_req_nxt;
   logic [PC_SIZE-1:0] flush_pc_nxt;
   logic [PC_SIZE-1:0] dpc_sel;
   logic               dpc_ena;
   logic [2:0]         dcause;
   logic               dcause_ena;
   logic               entry;
   logic               ack;

   // Only a real outstanding request can be acknowledged.
   assign ack = flush_ack & flush_req;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         flush_req <= 1'b0;
         flush_pc  <= '0;
      end else begin
         state     <= state_nxt;
         flush_req <= flush_req_nxt;
         flush_pc  <= flush_pc_nxt;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt     = state;
      flush_req_nxt = flush_req;
      flush_pc_nxt  = flush_pc;
      dpc_sel       = '0;
      dpc_ena       = 1'b0;
      dcause        = DCAUSE_NONE;
      dcause_ena    = 1'b0;
      entry         = 1'b0;

      case (state)
         ST_RUN, ST_STEP: begin
            if (cmt_valid & cmt_ebreak & dbg_ebreakm_r) begin
               entry   = 1'b1;
               dcause  = DCAUSE_EBREAK;
               dpc_sel = cmt_pc;
            end else if (dbg_irq_r) begin
               entry   = 1'b1;
               dcause  = DCAUSE_IRQ;
               dpc_sel = cmt_valid ? cmt_next_pc : nxt_pc;
            end else if (dbg_halt_r) begin
               entry   = 1'b1;
               dcause  = DCAUSE_HALT;
               dpc_sel = cmt_valid ? cmt_next_pc : nxt_pc;
            end else if ((state == ST_STEP) & cmt_valid) begin
               entry   = 1'b1;
               dcause  = DCAUSE_STEP;
               dpc_sel = cmt_next_pc;
            end
            if (entry) begin
               dpc_ena       = 1'b1;
               dcause_ena    = 1'b1;
               state_nxt     = ST_ENT_FLUSH;
               flush_req_nxt = 1'b1;
               flush_pc_nxt  = ROM_PC;
            end
         end
         ST_ENT_FLUSH: begin
            if (ack) begin
               state_nxt     = ST_DEBUG;
               flush_req_nxt = 1'b0;
            end
         end
         ST_DEBUG: begin
            // An ebreak inside debug mode just restarts the ROM; no capture.
            if (cmt_valid & cmt_ebreak) begin
               state_nxt     = ST_ENT_FLUSH;
               flush_req_nxt = 1'b1;
               flush_pc_nxt  = ROM_PC;
            end else if (cmt_valid & cmt_dret) begin
               dcause_ena    = 1'b1;
               state_nxt     = ST_EXIT_FLUSH;
               flush_req_nxt = 1'b1;
               flush_pc_nxt  = dpc_r;
            end
         end
         ST_EXIT_FLUSH: begin
            if (ack) begin
               state_nxt     = dbg_step_r ? ST_STEP : ST_RUN;
               flush_req_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt     = ST_RUN;
            flush_req_nxt = 1'b0;
         end
      endcase
   end

   // Mealy strobes are forced low while reset is asserted.
   assign cmt_dpc        = dpc_sel & {{(PC_SIZE-1){1'b1}}, 1'b0} & {PC_SIZE{rst_n}};
   assign cmt_dpc_ena    = dpc_ena & rst_n;
   assign cmt_dcause     = dcause & {3{rst_n}};
   assign cmt_dcause_ena = dcause_ena & rst_n;
   assign cmt_hold       = (state == ST_ENT_FLUSH) | (state == ST_EXIT_FLUSH);
   assign dbg_active     = (state == ST_DEBUG);

endmodule
